// File: rtl/regfile_wb_pkg.sv
// Shared widths, the zero-register index and the mult/div queue entry type
// for the register-file write scheduler.
package regfile_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(0);

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Producer handshakes, regfile write port and forwarding lookup bundle.
interface regfile_write_scheduler_if;
  import regfile_wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              md_valid;
  logic              md_ready;
  logic [REG_W-1:0]  md_rd;
  logic [DATA_W-1:0] md_data;
  logic              ctrl_writeEnable;
  logic [REG_W-1:0]  ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [REG_W-1:0]  lookup_reg;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;

  modport master (
    output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data, lookup_reg,
    input  alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           lookup_hit, lookup_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data, lookup_reg,
    output alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           lookup_hit, lookup_data
  );
endinterface

// File: rtl/wb_kill_fifo.sv
// In-order mult/div result queue with kill-by-rd; age-ordered read-out is
// built only when REGFILE_WB_LOOKUP_EN is defined.
module wb_kill_fifo
  import regfile_wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic             kill_i,
  input  logic [REG_W-1:0] kill_rd_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o
`ifdef REGFILE_WB_LOOKUP_EN
  ,
  output wb_entry_t        age_o [DEPTH]
`endif
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        entry_in;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));

  // Popped slots are invalidated so stale data can never match a lookup.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    entry_in = push_entry_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && (mem_q[i].rd == kill_rd_i)) mem_d[i].valid = 1'b0;
    end
    if (kill_i && (push_entry_i.rd == kill_rd_i)) entry_in.valid = 1'b0;
    if (pop_i) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_i) begin
      mem_d[wr_ptr_q] = entry_in;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef REGFILE_WB_LOOKUP_EN
  // Index 0 is the head (oldest), DEPTH-1 the youngest possible slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) age_o[i] = mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
  end
`endif

endmodule

// File: rtl/regfile_write_scheduler.sv
// Merges ALU and mult/div results onto the regfile write port with WAW kill.
// Optional forwarding lookup enabled by REGFILE_WB_LOOKUP_EN.
module regfile_write_scheduler
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                      clock,
  input logic                      ctrl_reset,
  regfile_write_scheduler_if.slave wb
);

  logic              we_q, we_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              full, empty;
  logic              alu_wr, push, pop;
  wb_entry_t         head, push_entry;
`ifdef REGFILE_WB_LOOKUP_EN
  wb_entry_t         age [DEPTH];
`endif

  assign wb.alu_ready        = !full;
  assign wb.md_ready         = !full;
  assign wb.ctrl_writeEnable = we_q;
  assign wb.ctrl_writeReg    = reg_q;
  assign wb.data_writeReg    = data_q;

  // Write selection: full-queue drain, then ALU, then queue drain.
  always_comb begin
    alu_wr           = !ctrl_reset && wb.alu_valid && !full && (wb.alu_rd != ZERO_REG);
    push             = !ctrl_reset && wb.md_valid && !full && (wb.md_rd != ZERO_REG);
    pop              = !ctrl_reset && !empty && (full || !alu_wr);
    push_entry.valid = 1'b1;
    push_entry.rd    = wb.md_rd;
    push_entry.data  = wb.md_data;
    we_d             = 1'b0;
    reg_d            = '0;
    data_d           = '0;
    if (pop) begin
      we_d   = head.valid;
      reg_d  = head.rd;
      data_d = head.data;
    end else if (alu_wr) begin
      we_d   = 1'b1;
      reg_d  = wb.alu_rd;
      data_d = wb.alu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  wb_kill_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (alu_wr),
    .kill_rd_i    (wb.alu_rd),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty)
`ifdef REGFILE_WB_LOOKUP_EN
    ,
    .age_o        (age)
`endif
  );

`ifdef REGFILE_WB_LOOKUP_EN
  // Oldest first so later (younger) matches override: output stage, head..tail.
  always_comb begin
    wb.lookup_hit  = 1'b0;
    wb.lookup_data = '0;
    if (wb.lookup_reg != ZERO_REG) begin
      if (we_q && (reg_q == wb.lookup_reg)) begin
        wb.lookup_hit  = 1'b1;
        wb.lookup_data = data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (age[i].valid && (age[i].rd == wb.lookup_reg)) begin
          wb.lookup_hit  = 1'b1;
          wb.lookup_data = age[i].data;
        end
      end
    end
  end
`else
  assign wb.lookup_hit  = 1'b0;
  assign wb.lookup_data = '0;
`endif

endmodule
